// File: rtl/quotient_unit_pkg.sv
// Shared definitions for the quotient unit and the multiplier system:
// default operand widths, address width and FSM state encoding.
package quotient_unit_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;
  localparam int unsigned AW     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DIVIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/quotient_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module quotient_unit_div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          q_o
);

  logic [VW:0] partial;
  logic [VW:0] diff;

  assign partial = {rem_i, bit_i};
  assign diff    = partial - {1'b0, divisor_i};
  assign q_o     = (partial >= {1'b0, divisor_i});
  // Remainder is always below the divisor, so the difference fits in VW bits.
  assign rem_o   = q_o ? diff[VW-1:0] : partial[VW-1:0];

endmodule

// File: rtl/quotient_unit.sv
// Sequential restoring divider: fetches dividend from RAM and divisor from ROM,
// produces one quotient bit per cycle, MSB first.
module quotient_unit
  import quotient_unit_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] adr_ram,
  input  logic [AW-1:0] adr_rom,
  output logic [AW-1:0] ram_adr,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_data,
  output logic [AW-1:0] rom_adr,
  input  logic [VW-1:0] rom_data,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  state_e        state_q, state_d;
  logic [AW-1:0] ram_adr_q, ram_adr_d;
  logic [AW-1:0] rom_adr_q, rom_adr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [VW-1:0] step_rem;
  logic          step_q;

  quotient_unit_div_step #(.VW(VW)) div_step (
    .rem_i     (rem_q),
    .bit_i     (dividend_q[cnt_q]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ram_adr_d  = ram_adr_q;
    rom_adr_d  = rom_adr_q;
    dz_d       = dz_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ram_adr_d = adr_ram;
          rom_adr_d = adr_rom;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        dividend_d = ram_data;
        divisor_d  = rom_data;
        quot_d     = '0;
        rem_d      = '0;
        dz_d       = 1'b0;
        if (rom_data == '0) begin
          dz_d    = 1'b1;
          quot_d  = '1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = CW'(DW - 1);
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        rem_d         = step_rem;
        quot_d[cnt_q] = step_q;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status strobes are registered against the state being entered.
    ram_rd_d = (state_d == ST_FETCH);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_DIVIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ram_adr_q  <= '0;
      rom_adr_q  <= '0;
      ram_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ram_adr_q  <= ram_adr_d;
      rom_adr_q  <= rom_adr_d;
      ram_rd_q   <= ram_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ram_adr   = ram_adr_q;
  assign rom_adr   = rom_adr_q;
  assign ram_rd    = ram_rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_quotient_unit.sv
// Self-checking bench for quotient_unit: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_quotient_unit;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    adr_ram, adr_rom;
  logic [2:0]    ram_adr, rom_adr;
  logic          ram_rd;
  logic [DW-1:0] ram_data;
  logic [VW-1:0] rom_data;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy, done, div_zero;

  logic [DW-1:0] mem [8];
  logic [VW-1:0] rom [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  quotient_unit #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .adr_ram(adr_ram), .adr_rom(adr_rom),
    .ram_adr(ram_adr), .ram_rd(ram_rd), .ram_data(ram_data),
    .rom_adr(rom_adr), .rom_data(rom_data),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Synchronous-read RAM and combinational ROM
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_adr];
  assign rom_data = rom[rom_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since the accepted start (t=1 is the first cycle after it)
  bit          m_act = 0;
  int          t = 0;
  int          m_lat = 0;
  logic [2:0]  m_ra = '0, m_rb = '0;
  int          m_a = 0, m_b = 0;
  int          m_q = 0, m_r = 0;
  bit          m_dz = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; t = 0; m_ra = '0; m_rb = '0;
      m_q = 0; m_r = 0; m_dz = 0;
      chk_en = 1;
    end else if (m_act) begin
      if (t == m_lat) m_act = 0;
      else begin
        t++;
        if (t == m_lat) begin
          m_dz = (m_b == 0);
          m_q  = m_dz ? (1 << DW) - 1 : m_a / m_b;
          m_r  = m_dz ? 0 : m_a % m_b;
        end
      end
    end else if (start) begin
      m_act = 1; t = 1;
      m_ra = adr_ram; m_rb = adr_rom;
      m_a = int'(mem[adr_ram]); m_b = int'(rom[adr_rom]);
      m_lat = (m_b == 0) ? 3 : DW + 3;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy",    32'(busy),    32'(m_act && t < m_lat));
      check("done",    32'(done),    32'(m_act && t == m_lat));
      check("ram_rd",  32'(ram_rd),  32'(m_act && t == 1));
      check("ram_adr", 32'(ram_adr), 32'(m_ra));
      check("rom_adr", 32'(rom_adr), 32'(m_rb));
      if (!m_act || t <= 2 || t == m_lat) begin
        check("quotient",  32'(quotient),  32'(m_q));
        check("remainder", 32'(remainder), 32'(m_r));
        check("div_zero",  32'(div_zero),  32'(m_dz));
      end
    end
  end

  // Launch one division and pin the result and latency against literals
  task automatic run(input int slot, input logic [DW-1:0] a, input logic [VW-1:0] b,
                     input int eq, input int er, input int edz, input int elat,
                     input bit extra);
    int n;
    int ndone;
    mem[slot] = a;
    rom[7 - slot] = b;
    @(negedge clk);
    adr_ram = 3'(slot); adr_rom = 3'(7 - slot); start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    while (done !== 1'b1 && n < 40) begin
      start = (extra && n == 6);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency",       32'(n),         32'(elat));
    check("lit_quotient",  32'(quotient),  32'(eq));
    check("lit_remainder", 32'(remainder), 32'(er));
    check("lit_div_zero",  32'(div_zero),  32'(edz));
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("single_done", 32'(ndone), 32'(0));
    check("held_quotient", 32'(quotient), 32'(eq));
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < 8; i++) begin mem[i] = '0; rom[i] = '0; end
    rst = 1'b1; start = 1'b0; adr_ram = '0; adr_rom = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
    check("rst_ram_adr",  32'(ram_adr),  32'(0));
    @(negedge clk);

    run(1, 8'd143, 4'd11, 13,  0, 0, 11, 1'b0);
    run(2, 8'd255, 4'd1,  255, 0, 0, 11, 1'b0);
    run(3, 8'd7,   4'd8,  0,   7, 0, 11, 1'b0);
    run(4, 8'd100, 4'd0,  255, 0, 1, 3,  1'b0);
    run(5, 8'd130, 4'd13, 10,  0, 0, 11, 1'b1);
    run(6, 8'd200, 4'd7,  28,  4, 0, 11, 1'b0);
    run(0, 8'd15,  4'd15, 1,   0, 0, 11, 1'b0);

    // Reset during the 4th DIVIDE cycle (t=6) aborts the division
    mem[2] = 8'd130; rom[5] = 4'd13;
    @(negedge clk);
    adr_ram = 3'd2; adr_rom = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      32'(busy),      32'(0));
    check("abort_done",      32'(done),      32'(0));
    check("abort_quotient",  32'(quotient),  32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_ram_adr",   32'(ram_adr),   32'(0));
    check("abort_rom_adr",   32'(rom_adr),   32'(0));
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'(0));

    run(3, 8'd143, 4'd11, 13, 0, 0, 11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
